// File: rtl/tlb_op_ctrl_if.sv
// Request/response channel between the CSR stage and the TLB maintenance sequencer.
// The CSR snapshot rides with the request so the sequencer can latch it at accept.
interface tlb_op_ctrl_if #(
    parameter int TLBNUM = 16
);
    localparam int IW = $clog2(TLBNUM);

    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [4:0]    inv_op;
    logic [9:0]    inv_asid;
    logic [18:0]   inv_vppn;
    logic [18:0]   csr_vppn;
    logic [9:0]    csr_asid;
    logic [IW-1:0] csr_index;
    logic [5:0]    csr_ps;
    logic          csr_ne;
    logic [26:0]   csr_elo0;
    logic [26:0]   csr_elo1;
    logic          csr_refill;

    logic          resp_valid;
    logic          resp_ready;
    logic [2:0]    resp_code;
    logic          res_ne;
    logic [IW-1:0] res_index;
    logic [18:0]   res_vppn;
    logic [5:0]    res_ps;
    logic [9:0]    res_asid;
    logic [26:0]   res_elo0;
    logic [26:0]   res_elo1;
    logic          res_err;

    modport master (
        output op_valid, op_code, inv_op, inv_asid, inv_vppn,
               csr_vppn, csr_asid, csr_index, csr_ps, csr_ne, csr_elo0, csr_elo1, csr_refill,
               resp_ready,
        input  op_ready, resp_valid, resp_code, res_ne, res_index, res_vppn, res_ps,
               res_asid, res_elo0, res_elo1, res_err
    );

    modport slave (
        input  op_valid, op_code, inv_op, inv_asid, inv_vppn,
               csr_vppn, csr_asid, csr_index, csr_ps, csr_ne, csr_elo0, csr_elo1, csr_refill,
               resp_ready,
        output op_ready, resp_valid, resp_code, res_ne, res_index, res_vppn, res_ps,
               res_asid, res_elo0, res_elo1, res_err
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: one op at a time, TLB ports driven for the single EXEC cycle.
// state | meaning:  IDLE accepting op | EXEC drive TLB, capture result | RESP hold result until taken
module tlb_op_ctrl #(
    parameter int  TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    tlb_op_ctrl_if.slave  req,

    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic          tlb_w_e,
    output logic [18:0]   tlb_w_vppn,
    output logic [5:0]    tlb_w_ps,
    output logic [9:0]    tlb_w_asid,
    output logic          tlb_w_g,
    output logic [19:0]   tlb_w_ppn0,
    output logic [1:0]    tlb_w_plv0,
    output logic [1:0]    tlb_w_mat0,
    output logic          tlb_w_d0,
    output logic          tlb_w_v0,
    output logic [19:0]   tlb_w_ppn1,
    output logic [1:0]    tlb_w_plv1,
    output logic [1:0]    tlb_w_mat1,
    output logic          tlb_w_d1,
    output logic          tlb_w_v1,

    output logic [IW-1:0] tlb_r_index,
    input  logic          tlb_r_e,
    input  logic [18:0]   tlb_r_vppn,
    input  logic [5:0]    tlb_r_ps,
    input  logic [9:0]    tlb_r_asid,
    input  logic          tlb_r_g,
    input  logic [19:0]   tlb_r_ppn0,
    input  logic [1:0]    tlb_r_plv0,
    input  logic [1:0]    tlb_r_mat0,
    input  logic          tlb_r_d0,
    input  logic          tlb_r_v0,
    input  logic [19:0]   tlb_r_ppn1,
    input  logic [1:0]    tlb_r_plv1,
    input  logic [1:0]    tlb_r_mat1,
    input  logic          tlb_r_d1,
    input  logic          tlb_r_v1,

    output logic          tlb_inv_valid,
    output logic [4:0]    tlb_inv_op,
    output logic [18:0]   tlb_s1_vppn,
    output logic [9:0]    tlb_s1_asid,
    output logic          tlb_s1_va_bit12,
    output logic          tlb_s1_sel,
    input  logic          tlb_s1_found,
    input  logic [IW-1:0] tlb_s1_index
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [2:0] OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_FILL = 3'd3, OP_INV = 3'd4;

    state_t        state;
    logic [IW-1:0] fill_cnt;
    logic [2:0]    op_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    inv_asid_q, asid_q;
    logic [18:0]   inv_vppn_q, vppn_q;
    logic [IW-1:0] index_q;
    logic [5:0]    ps_q;
    logic          ne_q, refill_q;
    logic [26:0]   elo0_q, elo1_q;

    logic [2:0]    resp_code_r;
    logic          res_ne_r, res_err_r;
    logic [IW-1:0] res_index_r;
    logic [18:0]   res_vppn_r;
    logic [5:0]    res_ps_r;
    logic [9:0]    res_asid_r;
    logic [26:0]   res_elo0_r, res_elo1_r;

    wire exec = (state == EXEC);

    assign req.op_ready   = (state == IDLE);
    assign req.resp_valid = (state == RESP);
    assign req.resp_code  = resp_code_r;
    assign req.res_ne     = res_ne_r;
    assign req.res_index  = res_index_r;
    assign req.res_vppn   = res_vppn_r;
    assign req.res_ps     = res_ps_r;
    assign req.res_asid   = res_asid_r;
    assign req.res_elo0   = res_elo0_r;
    assign req.res_elo1   = res_elo1_r;
    assign req.res_err    = res_err_r;

    // Strobes are gated by resetn so a reset landing in EXEC cannot commit a write.
    assign tlb_we        = exec && (op_q == OP_WR || op_q == OP_FILL) && resetn;
    assign tlb_inv_valid = exec && (op_q == OP_INV) && (inv_op_q <= 5'd6) && resetn;
    assign tlb_s1_sel    = exec && (op_q == OP_SRCH || op_q == OP_INV);

    assign tlb_w_index = (op_q == OP_FILL) ? fill_cnt : index_q;
    assign tlb_w_e     = refill_q | ~ne_q;
    assign tlb_w_vppn  = vppn_q;
    assign tlb_w_ps    = ps_q;
    assign tlb_w_asid  = asid_q;
    assign tlb_w_g     = elo0_q[6] & elo1_q[6];
    assign tlb_w_ppn0  = elo0_q[26:7];
    assign tlb_w_mat0  = elo0_q[5:4];
    assign tlb_w_plv0  = elo0_q[3:2];
    assign tlb_w_d0    = elo0_q[1];
    assign tlb_w_v0    = elo0_q[0];
    assign tlb_w_ppn1  = elo1_q[26:7];
    assign tlb_w_mat1  = elo1_q[5:4];
    assign tlb_w_plv1  = elo1_q[3:2];
    assign tlb_w_d1    = elo1_q[1];
    assign tlb_w_v1    = elo1_q[0];

    assign tlb_r_index     = index_q;
    assign tlb_inv_op      = inv_op_q;
    assign tlb_s1_vppn     = (op_q == OP_INV) ? inv_vppn_q : vppn_q;
    assign tlb_s1_asid     = (op_q == OP_INV) ? inv_asid_q : asid_q;
    assign tlb_s1_va_bit12 = 1'b0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            fill_cnt    <= '0;
            op_q        <= '0;
            inv_op_q    <= '0;
            inv_asid_q  <= '0;
            inv_vppn_q  <= '0;
            vppn_q      <= '0;
            asid_q      <= '0;
            index_q     <= '0;
            ps_q        <= '0;
            ne_q        <= 1'b0;
            refill_q    <= 1'b0;
            elo0_q      <= '0;
            elo1_q      <= '0;
            resp_code_r <= '0;
            res_ne_r    <= 1'b0;
            res_index_r <= '0;
            res_vppn_r  <= '0;
            res_ps_r    <= '0;
            res_asid_r  <= '0;
            res_elo0_r  <= '0;
            res_elo1_r  <= '0;
            res_err_r   <= 1'b0;
        end else begin
            fill_cnt <= (fill_cnt == IW'(TLBNUM - 1)) ? '0 : fill_cnt + 1'b1;
            case (state)
                IDLE: if (req.op_valid) begin
                    op_q       <= req.op_code;
                    inv_op_q   <= req.inv_op;
                    inv_asid_q <= req.inv_asid;
                    inv_vppn_q <= req.inv_vppn;
                    vppn_q     <= req.csr_vppn;
                    asid_q     <= req.csr_asid;
                    index_q    <= req.csr_index;
                    ps_q       <= req.csr_ps;
                    ne_q       <= req.csr_ne;
                    refill_q   <= req.csr_refill;
                    elo0_q     <= req.csr_elo0;
                    elo1_q     <= req.csr_elo1;
                    state      <= EXEC;
                end
                EXEC: begin
                    state       <= RESP;
                    resp_code_r <= op_q;
                    res_ne_r    <= 1'b0;
                    res_index_r <= '0;
                    res_vppn_r  <= '0;
                    res_ps_r    <= '0;
                    res_asid_r  <= '0;
                    res_elo0_r  <= '0;
                    res_elo1_r  <= '0;
                    res_err_r   <= 1'b0;
                    case (op_q)
                        OP_SRCH: begin
                            res_ne_r    <= ~tlb_s1_found;
                            res_index_r <= tlb_s1_found ? tlb_s1_index : index_q;
                        end
                        OP_RD: if (tlb_r_e) begin
                            res_index_r <= index_q;
                            res_vppn_r  <= tlb_r_vppn;
                            res_ps_r    <= tlb_r_ps;
                            res_asid_r  <= tlb_r_asid;
                            res_elo0_r  <= {tlb_r_ppn0, tlb_r_g, tlb_r_mat0, tlb_r_plv0, tlb_r_d0, tlb_r_v0};
                            res_elo1_r  <= {tlb_r_ppn1, tlb_r_g, tlb_r_mat1, tlb_r_plv1, tlb_r_d1, tlb_r_v1};
                        end else begin
                            res_ne_r <= 1'b1;
                        end
                        OP_WR:   res_index_r <= index_q;
                        OP_FILL: res_index_r <= fill_cnt;
                        OP_INV:  res_err_r   <= (inv_op_q > 5'd6);
                        default: res_err_r   <= 1'b1;
                    endcase
                end
                RESP: if (req.resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a behavioural 16-entry TLB and a response scoreboard.
module tb_tlb_op_ctrl;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    tlb_op_ctrl_if #(.TLBNUM(16)) bus ();

    logic        tlb_we, tlb_w_e, tlb_w_g, tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
    logic [3:0]  tlb_w_index, tlb_r_index, tlb_s1_index;
    logic [18:0] tlb_w_vppn, tlb_r_vppn, tlb_s1_vppn;
    logic [5:0]  tlb_w_ps, tlb_r_ps;
    logic [9:0]  tlb_w_asid, tlb_r_asid, tlb_s1_asid;
    logic [19:0] tlb_w_ppn0, tlb_w_ppn1, tlb_r_ppn0, tlb_r_ppn1;
    logic [1:0]  tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;
    logic [1:0]  tlb_r_plv0, tlb_r_mat0, tlb_r_plv1, tlb_r_mat1;
    logic        tlb_r_e, tlb_r_g, tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
    logic        tlb_inv_valid, tlb_s1_va_bit12, tlb_s1_sel, tlb_s1_found;
    logic [4:0]  tlb_inv_op;

    tlb_op_ctrl #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn), .req(bus),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn),
        .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
        .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0),
        .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0),
        .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1), .tlb_w_mat1(tlb_w_mat1),
        .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
        .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_vppn(tlb_r_vppn), .tlb_r_ps(tlb_r_ps),
        .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
        .tlb_r_ppn0(tlb_r_ppn0), .tlb_r_plv0(tlb_r_plv0), .tlb_r_mat0(tlb_r_mat0),
        .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
        .tlb_r_ppn1(tlb_r_ppn1), .tlb_r_plv1(tlb_r_plv1), .tlb_r_mat1(tlb_r_mat1),
        .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
        .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op),
        .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_asid(tlb_s1_asid), .tlb_s1_va_bit12(tlb_s1_va_bit12),
        .tlb_s1_sel(tlb_s1_sel), .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index)
    );

    // Behavioural TLB; entries are cleared while resetn is low.
    logic        m_e    [16];
    logic [18:0] m_vppn [16];
    logic [5:0]  m_ps   [16];
    logic [9:0]  m_asid [16];
    logic        m_g    [16];
    logic [25:0] m_lo0  [16];
    logic [25:0] m_lo1  [16];
    logic [3:0]  m_fill;
    int          we_cnt, inv_cnt;
    logic [3:0]  last_w_idx;

    function automatic logic vmatch(input int i, input logic [18:0] va);
        return (m_ps[i] == 6'd21) ? (m_vppn[i][18:9] == va[18:9]) : (m_vppn[i] == va);
    endfunction

    function automatic logic inv_hit(input int i, input logic [4:0] op, input logic [9:0] asid,
                                     input logic [18:0] va);
        logic am;
        am = (m_asid[i] == asid);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return m_g[i];
            5'd3:       return !m_g[i];
            5'd4:       return !m_g[i] && am;
            5'd5:       return !m_g[i] && am && vmatch(i, va);
            5'd6:       return (m_g[i] || am) && vmatch(i, va);
            default:    return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        m_fill <= resetn ? m_fill + 4'd1 : 4'd0;
        if (tlb_we) begin
            we_cnt     <= we_cnt + 1;
            last_w_idx <= tlb_w_index;
        end
        if (tlb_inv_valid) inv_cnt <= inv_cnt + 1;
        if (!resetn) begin
            for (int i = 0; i < 16; i++) m_e[i] <= 1'b0;
        end else begin
            if (tlb_we) begin
                m_e[tlb_w_index]    <= tlb_w_e;
                m_vppn[tlb_w_index] <= tlb_w_vppn;
                m_ps[tlb_w_index]   <= tlb_w_ps;
                m_asid[tlb_w_index] <= tlb_w_asid;
                m_g[tlb_w_index]    <= tlb_w_g;
                m_lo0[tlb_w_index]  <= {tlb_w_ppn0, tlb_w_mat0, tlb_w_plv0, tlb_w_d0, tlb_w_v0};
                m_lo1[tlb_w_index]  <= {tlb_w_ppn1, tlb_w_mat1, tlb_w_plv1, tlb_w_d1, tlb_w_v1};
            end
            if (tlb_inv_valid)
                for (int i = 0; i < 16; i++)
                    if (m_e[i] && inv_hit(i, tlb_inv_op, tlb_s1_asid, tlb_s1_vppn)) m_e[i] <= 1'b0;
        end
    end

    always_comb begin
        tlb_s1_found = 1'b0;
        tlb_s1_index = '0;
        for (int i = 0; i < 16; i++)
            if (m_e[i] && (m_g[i] || m_asid[i] == tlb_s1_asid) && vmatch(i, tlb_s1_vppn)) begin
                tlb_s1_found = 1'b1;
                tlb_s1_index = 4'(i);
            end
    end

    assign tlb_r_e    = m_e[tlb_r_index];
    assign tlb_r_vppn = m_vppn[tlb_r_index];
    assign tlb_r_ps   = m_ps[tlb_r_index];
    assign tlb_r_asid = m_asid[tlb_r_index];
    assign tlb_r_g    = m_g[tlb_r_index];
    assign {tlb_r_ppn0, tlb_r_mat0, tlb_r_plv0, tlb_r_d0, tlb_r_v0} = m_lo0[tlb_r_index];
    assign {tlb_r_ppn1, tlb_r_mat1, tlb_r_plv1, tlb_r_d1, tlb_r_v1} = m_lo1[tlb_r_index];

    typedef struct packed {
        logic [2:0]  code;
        logic        ne;
        logic [3:0]  idx;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic [26:0] elo0;
        logic [26:0] elo1;
        logic        err;
    } resp_t;

    resp_t sb[$];
    int    checks = 0;
    int    failures = 0;

    function automatic resp_t mk(input logic [2:0] c);
        resp_t r;
        r = '0;
        r.code = c;
        return r;
    endfunction

    function automatic resp_t observed();
        return {bus.resp_code, bus.res_ne, bus.res_index, bus.res_vppn, bus.res_ps, bus.res_asid,
                bus.res_elo0, bus.res_elo1, bus.res_err};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_csr(input logic [3:0] idx, input logic [18:0] vppn, input logic [9:0] asid,
                           input logic [5:0] ps, input logic ne, input logic refill,
                           input logic [26:0] e0, input logic [26:0] e1);
        bus.csr_index = idx;  bus.csr_vppn = vppn; bus.csr_asid = asid; bus.csr_ps = ps;
        bus.csr_ne = ne;      bus.csr_refill = refill; bus.csr_elo0 = e0; bus.csr_elo1 = e1;
    endtask

    // Called at a negedge while the DUT is idle; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] code, input resp_t exp, input bit push);
        bus.op_code  = code;
        bus.op_valid = 1'b1;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        if (push) sb.push_back(exp);
    endtask

    task automatic get_resp(input string tag);
        int n;
        resp_t exp;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 128'(bus.resp_valid), 128'(1'b1));
        if (bus.resp_valid && sb.size() > 0) begin
            exp = sb.pop_front();
            chk(tag, 128'(observed()), 128'(exp));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fill(input logic [3:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (m_fill != v && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    localparam logic [26:0] ELO0_A = {20'h00AAA, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1};
    localparam logic [26:0] ELO1_A = {20'h00BBB, 1'b0, 2'b01, 2'b11, 1'b0, 1'b1};
    localparam logic [26:0] ELO0_F = {20'h12345, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0};
    localparam logic [26:0] ELO1_F = {20'h6789A, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1};

    initial begin
        resp_t e;
        int    w0, i0;
        bit    seen;

        resetn = 1'b0;
        bus.op_valid = 1'b0; bus.op_code = '0; bus.resp_ready = 1'b1;
        bus.inv_op = '0; bus.inv_asid = '0; bus.inv_vppn = '0;
        set_csr(4'd0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_op_ready", 128'(bus.op_ready), 128'(1'b1));
        chk("rst_resp_valid", 128'(bus.resp_valid), 128'(1'b0));
        chk("rst_res", 128'(observed()), 128'(0));
        chk("rst_tlb_ctl", 128'({tlb_we, tlb_inv_valid, tlb_s1_sel}), 128'(3'b000));
        resetn = 1'b1;

        // TLBWR index 3
        @(negedge clk);
        set_csr(4'd3, 19'h12345, 10'h055, 6'd12, 1'b0, 1'b0, ELO0_A, ELO1_A);
        w0 = we_cnt;
        e = mk(3'd2); e.idx = 4'd3;
        issue(3'd2, e, 1'b1);
        get_resp("wr3");
        chk("wr3_we_pulses", 128'(we_cnt - w0), 128'(1));
        chk("wr3_w_index", 128'(last_w_idx), 128'(4'd3));

        // TLBRD index 3
        @(negedge clk);
        e = mk(3'd1); e.idx = 4'd3; e.vppn = 19'h12345; e.ps = 6'd12; e.asid = 10'h055;
        e.elo0 = ELO0_A; e.elo1 = ELO1_A;
        issue(3'd1, e, 1'b1);
        get_resp("rd3");

        // TLBSRCH hit, then miss
        @(negedge clk);
        bus.csr_index = 4'd9;
        e = mk(3'd0); e.idx = 4'd3;
        issue(3'd0, e, 1'b1);
        get_resp("srch_hit");
        @(negedge clk);
        bus.csr_vppn = 19'h00001;
        e = mk(3'd0); e.ne = 1'b1; e.idx = 4'd9;
        issue(3'd0, e, 1'b1);
        get_resp("srch_miss");

        // TLBRD on empty index 7
        @(negedge clk);
        bus.csr_index = 4'd7;
        e = mk(3'd1); e.ne = 1'b1;
        issue(3'd1, e, 1'b1);
        get_resp("rd_empty");

        // TLBFILL with fill_cnt = 15 in EXEC, then with fill_cnt wrapped to 0
        set_csr(4'd2, 19'h0ABCD, 10'h011, 6'd12, 1'b1, 1'b1, ELO0_F, ELO1_F);
        wait_fill(4'd14);
        e = mk(3'd3); e.idx = 4'd15;
        issue(3'd3, e, 1'b1);
        get_resp("fill15");
        chk("fill15_w_index", 128'(last_w_idx), 128'(4'd15));
        bus.csr_vppn = 19'h0DCBA; bus.csr_ne = 1'b0; bus.csr_refill = 1'b0;
        wait_fill(4'd15);
        e = mk(3'd3); e.idx = 4'd0;
        issue(3'd3, e, 1'b1);
        get_resp("fill_wrap0");
        chk("fill0_w_index", 128'(last_w_idx), 128'(4'd0));
        @(negedge clk);
        bus.csr_index = 4'd0;
        e = mk(3'd1); e.idx = 4'd0; e.vppn = 19'h0DCBA; e.ps = 6'd12; e.asid = 10'h011;
        e.elo0 = ELO0_F; e.elo1 = ELO1_F;
        issue(3'd1, e, 1'b1);
        get_resp("rd_fill0");

        // INVTLB op 5 on entry 3, then search misses
        @(negedge clk);
        bus.inv_op = 5'd5; bus.inv_asid = 10'h055; bus.inv_vppn = 19'h12345;
        i0 = inv_cnt;
        issue(3'd4, mk(3'd4), 1'b1);
        get_resp("inv5");
        chk("inv5_pulses", 128'(inv_cnt - i0), 128'(1));
        @(negedge clk);
        set_csr(4'd5, 19'h12345, 10'h055, 6'd12, 1'b0, 1'b0, ELO0_A, ELO1_A);
        e = mk(3'd0); e.ne = 1'b1; e.idx = 4'd5;
        issue(3'd0, e, 1'b1);
        get_resp("srch_after_inv");

        // INVTLB op 7 and reserved opcode
        @(negedge clk);
        bus.inv_op = 5'd7;
        i0 = inv_cnt;
        e = mk(3'd4); e.err = 1'b1;
        issue(3'd4, e, 1'b1);
        get_resp("inv7");
        chk("inv7_pulses", 128'(inv_cnt - i0), 128'(0));
        @(negedge clk);
        w0 = we_cnt;
        e = mk(3'd6); e.err = 1'b1;
        issue(3'd6, e, 1'b1);
        get_resp("rsvd6");
        chk("rsvd6_we", 128'(we_cnt - w0), 128'(0));

        // Back-pressure: hold resp_ready low for 5 cycles
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.csr_index = 4'd4;
        e = mk(3'd2); e.idx = 4'd4;
        issue(3'd2, e, 1'b1);
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", 128'(bus.resp_valid), 128'(1'b1));
            chk("bp_op_ready", 128'(bus.op_ready), 128'(1'b0));
            chk("bp_res_stable", 128'(observed()), 128'(e));
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 128'({bus.resp_valid, bus.op_ready}), 128'(2'b01));

        // Reset during EXEC of a TLBWR
        @(negedge clk);
        bus.csr_index = 4'd6;
        w0 = we_cnt;
        issue(3'd2, mk(3'd2), 1'b0);
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        chk("rst_exec_no_write", 128'(we_cnt - w0), 128'(0));
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("rst_exec_no_resp", 128'(seen), 128'(1'b0));
        chk("rst_exec_idle", 128'(bus.op_ready), 128'(1'b1));
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
